// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the forwarding/hazard unit: select encoding, tracker entry, clog2.
package fwd_pkg;

    localparam int FWD_SEL_RF = 0;
    localparam int TRK_RD_W   = 8;

    // Tracker rd is stored at a fixed width; narrower register addresses are zero-extended.
    typedef struct packed {
        logic                valid;
        logic [TRK_RD_W-1:0] rd;
        logic                we;
        logic                is_load;
    } trk_entry_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return (res < 1) ? 1 : res;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Issue-side bundle of the forwarding unit; master drives ID issue/flush, slave returns stall and EX selects.
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
);
    logic                      issue_valid;
    logic [NUM_SRC*REG_AW-1:0] issue_rs;
    logic [NUM_SRC-1:0]        issue_rs_used;
    logic [REG_AW-1:0]         issue_rd;
    logic                      issue_we;
    logic                      issue_is_load;
    logic                      flush;
    logic                      stall;
    logic                      ex_valid;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rs_used, issue_rd, issue_we, issue_is_load, flush,
        input  stall, ex_valid, fwd_sel, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rs_used, issue_rd, issue_we, issue_is_load, flush,
        output stall, ex_valid, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit_src_resolve.sv
// Priority match of one source against the tracker: youngest matching entry gives sel, load too young gives hazard.
// Purely combinational, no handshake.
module fwd_src_resolve
    import fwd_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int FWD_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = 2
) (
    input  logic [REG_AW-1:0]                rs_i,
    input  logic                             used_i,
    input  trk_entry_t [FWD_STAGES-1:0]      trk_i,
    output logic [SEL_W-1:0]                 sel_o,
    output logic                             hazard_o
);
    logic [TRK_RD_W-1:0] rs_ext;
    logic                found;

    assign rs_ext = TRK_RD_W'(rs_i);

    always_comb begin
        sel_o    = SEL_W'(FWD_SEL_RF);
        hazard_o = 1'b0;
        found    = 1'b0;
        for (int j = 0; j < FWD_STAGES; j++) begin
            if (!found && used_i && trk_i[j].valid && trk_i[j].we &&
                (trk_i[j].rd != '0) && (trk_i[j].rd == rs_ext)) begin
                found    = 1'b1;
                sel_o    = SEL_W'(j + 1);
                // Only the youngest match decides the stall; older matches never get a say.
                hazard_o = trk_i[j].is_load && ((j + 1) < LOAD_READY_STAGE);
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destinations, registers per-source forward selects for EX, raises load-use stall.
// Selects/ex_valid one cycle after issue; stall is same-cycle and holds ID, a bubble enters EX instead.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW           = 5,
    parameter int NUM_SRC          = 2,
    parameter int FWD_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);
    localparam int SEL_W = clog2(FWD_STAGES + 1);

    trk_entry_t [FWD_STAGES-1:0]   trk_q, trk_d;
    logic [NUM_SRC-1:0][SEL_W-1:0] sel_w;
    logic [NUM_SRC-1:0]            hazard_w;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel_q, fwd_sel_d;
    logic                          ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
    logic                          stall_w;
    logic                          accept_w;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_src_resolve #(
            .REG_AW           (REG_AW),
            .FWD_STAGES       (FWD_STAGES),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_W            (SEL_W)
        ) u_resolve (
            .rs_i     (bus.issue_rs[k*REG_AW +: REG_AW]),
            .used_i   (bus.issue_rs_used[k]),
            .trk_i    (trk_q),
            .sel_o    (sel_w[k]),
            .hazard_o (hazard_w[k])
        );
    end

    // Flush wins over everything in ID, so it also masks the stall.
    assign stall_w  = bus.issue_valid && !bus.flush && (|hazard_w);
    assign accept_w = bus.issue_valid && !bus.flush && !stall_w;

    always_comb begin
        trk_d = trk_q;
        for (int j = FWD_STAGES - 1; j > 0; j--) begin
            trk_d[j] = trk_q[j-1];
        end
        trk_d[0]    = '0;
        ex_valid_d  = accept_w;
        fwd_sel_d   = '0;
        stall_cnt_d = stall_cnt_q;
        if (accept_w) begin
            trk_d[0].valid   = 1'b1;
            trk_d[0].rd      = TRK_RD_W'(bus.issue_rd);
            trk_d[0].we      = bus.issue_we;
            trk_d[0].is_load = bus.issue_is_load;
            fwd_sel_d        = sel_w;
        end
        if (stall_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_q       <= '0;
            ex_valid_q  <= 1'b0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            trk_q       <= trk_d;
            ex_valid_q  <= ex_valid_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall     = stall_w;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.fwd_sel   = fwd_sel_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; a second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_fwd_hazard_unit;
    localparam int REG_AW = 5;
    localparam int NSRC   = 2;
    localparam int SEL_W  = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fwd_hazard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NSRC), .SEL_W(SEL_W), .CNT_W(16)) bus ();
    fwd_hazard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NSRC), .SEL_W(SEL_W), .CNT_W(2))  bus2 ();

    fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NSRC), .FWD_STAGES(2), .LOAD_READY_STAGE(2), .CNT_W(16))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NSRC), .FWD_STAGES(2), .LOAD_READY_STAGE(2), .CNT_W(2))
        u_dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus2.issue_valid   = bus.issue_valid;
    assign bus2.issue_rs      = bus.issue_rs;
    assign bus2.issue_rs_used = bus.issue_rs_used;
    assign bus2.issue_rd      = bus.issue_rd;
    assign bus2.issue_we      = bus.issue_we;
    assign bus2.issue_is_load = bus.issue_is_load;
    assign bus2.flush         = bus.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                         input logic [4:0] rd, input logic we, input logic ld, input logic fl);
        bus.issue_valid   = 1'b1;
        bus.issue_rs      = {rs1, rs0};
        bus.issue_rs_used = used;
        bus.issue_rd      = rd;
        bus.issue_we      = we;
        bus.issue_is_load = ld;
        bus.flush         = fl;
        #1;
    endtask

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_rs      = '0;
        bus.issue_rs_used = '0;
        bus.issue_rd      = '0;
        bus.issue_we      = 1'b0;
        bus.issue_is_load = 1'b0;
        bus.flush         = 1'b0;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] sel(input int k);
        logic [NSRC*SEL_W-1:0] v;
        v = bus.fwd_sel;
        return v[k*SEL_W +: SEL_W];
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle();
        #10;
        check_eq("rst_stall", {31'd0, bus.stall}, 0);
        check_eq("rst_ex_valid", {31'd0, bus.ex_valid}, 0);
        check_eq("rst_fwd_sel", {28'd0, bus.fwd_sel}, 0);
        check_eq("rst_stall_cnt", {16'd0, bus.stall_cnt}, 0);
        rst_n = 1'b1;
        step();

        // ALU back-to-back
        issue(0, 0, 2'b00, 3, 1, 0, 0);
        step();
        issue(3, 0, 2'b01, 10, 1, 0, 0);
        check_eq("b2b_stall", {31'd0, bus.stall}, 0);
        step();
        check_eq("b2b_sel0", {30'd0, sel(0)}, 1);
        check_eq("b2b_ex_valid", {31'd0, bus.ex_valid}, 1);

        // Distance 2 and distance 3
        issue(0, 0, 2'b00, 3, 1, 0, 0); step();
        issue(0, 0, 2'b00, 7, 1, 0, 0); step();
        issue(0, 3, 2'b10, 9, 1, 0, 0); step();
        check_eq("dist2_sel1", {30'd0, sel(1)}, 2);
        check_eq("dist2_sel0", {30'd0, sel(0)}, 0);
        issue(0, 0, 2'b00, 3, 1, 0, 0); step();
        issue(0, 0, 2'b00, 7, 1, 0, 0); step();
        issue(0, 0, 2'b00, 7, 1, 0, 0); step();
        issue(0, 3, 2'b10, 9, 1, 0, 0); step();
        check_eq("dist3_sel1", {30'd0, sel(1)}, 0);
        check_eq("dist3_ex_valid", {31'd0, bus.ex_valid}, 1);

        // Load-use
        issue(0, 0, 2'b00, 5, 1, 1, 0); step();
        issue(0, 5, 2'b10, 11, 1, 0, 0);
        check_eq("lu_stall", {31'd0, bus.stall}, 1);
        step();
        check_eq("lu_bubble", {31'd0, bus.ex_valid}, 0);
        check_eq("lu_restall", {31'd0, bus.stall}, 0);
        step();
        check_eq("lu_sel1", {30'd0, sel(1)}, 2);
        check_eq("lu_ex_valid", {31'd0, bus.ex_valid}, 1);
        check_eq("lu_cnt", {16'd0, bus.stall_cnt}, 1);

        // Zero register never forwards or stalls
        issue(0, 0, 2'b00, 0, 1, 0, 0); step();
        issue(0, 0, 2'b01, 12, 1, 0, 0); step();
        check_eq("r0_sel0", {30'd0, sel(0)}, 0);
        issue(0, 0, 2'b00, 0, 1, 1, 0); step();
        issue(0, 0, 2'b01, 12, 1, 0, 0);
        check_eq("r0_load_stall", {31'd0, bus.stall}, 0);
        step();

        // Youngest wins; identical rs on both sources
        issue(0, 0, 2'b00, 4, 1, 0, 0); step();
        issue(0, 0, 2'b00, 4, 1, 0, 0); step();
        issue(4, 4, 2'b11, 13, 1, 0, 0); step();
        check_eq("young_sel0", {30'd0, sel(0)}, 1);
        check_eq("young_sel1", {30'd0, sel(1)}, 1);

        // Youngest load stalls even though an older ALU result exists
        issue(0, 0, 2'b00, 6, 1, 0, 0); step();
        issue(0, 0, 2'b00, 6, 1, 1, 0); step();
        issue(6, 0, 2'b01, 14, 1, 0, 0);
        check_eq("young_ld_stall", {31'd0, bus.stall}, 1);
        step();
        check_eq("young_ld_restall", {31'd0, bus.stall}, 0);
        step();
        check_eq("young_ld_sel0", {30'd0, sel(0)}, 2);
        check_eq("young_ld_cnt", {16'd0, bus.stall_cnt}, 2);

        // Flush during hazard; the load in EX keeps shifting
        issue(0, 0, 2'b00, 5, 1, 1, 0); step();
        issue(0, 5, 2'b10, 11, 1, 0, 1);
        check_eq("flush_stall", {31'd0, bus.stall}, 0);
        step();
        check_eq("flush_ex_valid", {31'd0, bus.ex_valid}, 0);
        check_eq("flush_cnt", {16'd0, bus.stall_cnt}, 2);
        issue(0, 5, 2'b10, 11, 1, 0, 0);
        check_eq("flush_after_stall", {31'd0, bus.stall}, 0);
        step();
        check_eq("flush_after_sel1", {30'd0, sel(1)}, 2);

        // Three more load-use stalls: 5 total, 2-bit counter must stick at 3
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 2'b00, 5, 1, 1, 0); step();
            issue(0, 5, 2'b10, 11, 1, 0, 0);
            check_eq("sat_stall", {31'd0, bus.stall}, 1);
            step(); step();
        end
        check_eq("sat_cnt_wide", {16'd0, bus.stall_cnt}, 5);
        check_eq("sat_cnt_narrow", {30'd0, bus2.stall_cnt}, 3);

        // Asynchronous reset between edges with a stall pending
        issue(0, 0, 2'b00, 5, 1, 1, 0); step();
        issue(0, 5, 2'b10, 11, 1, 0, 0);
        check_eq("pre_rst_stall", {31'd0, bus.stall}, 1);
        check_eq("pre_rst_ex_valid", {31'd0, bus.ex_valid}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_stall", {31'd0, bus.stall}, 0);
        check_eq("arst_ex_valid", {31'd0, bus.ex_valid}, 0);
        check_eq("arst_fwd_sel", {28'd0, bus.fwd_sel}, 0);
        check_eq("arst_cnt", {16'd0, bus.stall_cnt}, 0);
        check_eq("arst_cnt_narrow", {30'd0, bus2.stall_cnt}, 0);
        idle();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
